// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - hz_state_e    : sequencer FSM encoding (RUN / MDU_WAIT)
//   - REG_ZERO      : architectural x0, which never creates a data hazard
//   - CNT_W_DEFAULT : default width of the performance counters
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 32;

endpackage

// File: rtl/hazard_perf_counters.sv
// -----------------------------------------------------------------------------
// hazard_perf_counters
// Two free-running CNT_W-bit counters with individual enables. Both wrap
// modulo 2^CNT_W and clear on synchronous reset.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   stall_en_i       : count this cycle as a stall cycle
//   flush_en_i       : count this cycle as a flush cycle
//   stall_cycles_o   : stall cycle count
//   flush_count_o    : flush cycle count
// -----------------------------------------------------------------------------
module hazard_perf_counters
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_en_i,
  input  logic             flush_en_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  logic [1:0] en;
  assign en = {flush_en_i, stall_en_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (en[gi]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign stall_cycles_o = g_cnt[0].cnt_q;
  assign flush_count_o  = g_cnt[1].cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RV32IM pipeline.
// Inputs : ID source registers/usage, EX destination/load/writeback flags,
//          EX taken branch, MDU request/done, imem/dmem busywait.
// Outputs: hold (stall) controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB;
//          bubble (flush) controls for IF/ID, ID/EX, EX/MEM;
//          mdu_busy_o (FSM waiting on a multi-cycle MDU op);
//          stall/flush performance counters.
// Controls are combinational from the registered FSM state and the current
// inputs; stage registers sample them on the next rising edge.
// Priority: reset > memory wait > MDU > taken branch > load-use.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_label_id_i,
  input  logic [4:0]       rs2_label_id_i,
  input  logic             rs1_used_id_i,
  input  logic             rs2_used_id_i,
  input  logic [4:0]       rd_id_ex_i,
  input  logic             is_load_id_ex_i,
  input  logic             reg_wb_en_id_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic             mdu_req_ex_i,
  input  logic             mdu_done_i,
  input  logic             imem_busywait_i,
  input  logic             dmem_busywait_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  hz_state_e state_q;
  hz_state_e state_d;

  logic mem_wait;
  logic mdu_hold;
  logic load_use;

  assign mem_wait = imem_busywait_i | dmem_busywait_i;

  // Hold the front end while a multi-cycle MDU op is outstanding. A request
  // that completes in the same cycle (single-cycle mul) never holds.
  assign mdu_hold = ((state_q == ST_RUN) && mdu_req_ex_i && !mdu_done_i) ||
                    ((state_q == ST_MDU_WAIT) && !mdu_done_i);

  assign load_use = is_load_id_ex_i && reg_wb_en_id_ex_i &&
                    (rd_id_ex_i != REG_ZERO) &&
                    ((rs1_used_id_i && (rs1_label_id_i == rd_id_ex_i)) ||
                     (rs2_used_id_i && (rs2_label_id_i == rd_id_ex_i)));

  always_comb begin
    state_d        = state_q;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_stall_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mdu_busy_o     = 1'b0;

    if (rst_i) begin
      // Bubble the front stage registers so they clear alongside the FSM.
      state_d        = ST_RUN;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else begin
      mdu_busy_o = (state_q == ST_MDU_WAIT);
      if (mem_wait) begin
        // Freeze everything, FSM included; a taken branch stays in EX and
        // reasserts once memory is ready, so its flush is not lost.
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_stall_o = 1'b1;
      end else if (mdu_hold) begin
        // EX is occupied by the MDU op; feed bubbles into MEM meanwhile.
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
        state_d        = ST_MDU_WAIT;
      end else begin
        // Reaching here in MDU_WAIT means done arrived with memory ready.
        state_d = ST_RUN;
        if (branch_taken_ex_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (load_use) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_en_i     (pc_stall_o),
    .flush_en_i     (if_id_flush_o | id_ex_flush_o | ex_mem_flush_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

endmodule
